// File: rtl/bpu_param_predictor_if.sv
// Signal bundle between the branch predictor and its surroundings:
// the PREIF/IF stage request side, the EXE-stage resolution side, and the
// registered prediction handed to PC select.
interface bpu_param_predictor_if;
   // IF/PREIF side
   logic        if_wr;
   logic        if_flush;
   logic [31:0] preif_pc;
   // EXE resolution side
   logic        exe_valid;
   logic [31:0] exe_pc;
   logic [31:0] exe_target;
   logic [1:0]  exe_type;
   logic        exe_taken;
   logic        exe_hit;
   logic [1:0]  exe_count;
   // prediction outputs
   logic [31:0] target;
   logic        pred_taken;
   logic [1:0]  pred_type;
   logic        pred_hit;
   logic [1:0]  pred_count;
   logic        pred_valid;
   logic        ras_empty;

   modport master (
      output if_wr, if_flush, preif_pc,
      output exe_valid, exe_pc, exe_target, exe_type, exe_taken, exe_hit, exe_count,
      input  target, pred_taken, pred_type, pred_hit, pred_count, pred_valid, ras_empty
   );

   modport slave (
      input  if_wr, if_flush, preif_pc,
      input  exe_valid, exe_pc, exe_target, exe_type, exe_taken, exe_hit, exe_count,
      output target, pred_taken, pred_type, pred_hit, pred_count, pred_valid, ras_empty
   );
endinterface

// File: rtl/bpu_param_predictor.sv
// Parametrised branch predictor sitting between PREIF and IF.
// Direct-mapped tagged BHT (2-bit counters + stored target + type), a circular
// return-address stack with occupancy tracking, and a prediction register that
// captures one lookup per IF advance.
// Optional feature macro: BPU_GSHARE_EN (XORs a global history register into
// the BHT index for both lookup and update; tags stay unchanged).
module bpu_param_predictor #(
   parameter int BHT_DEPTH = 512,
   parameter int RAS_DEPTH = 8,
   parameter int GHR_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bpu_param_predictor_if.slave bus
);

   localparam int IDX   = $clog2(BHT_DEPTH);
   localparam int TAG_W = 32 - IDX - 2;
   localparam int RAS_W = $clog2(RAS_DEPTH);

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_IMME = 2'b01;
   localparam logic [1:0] T_CALL = 2'b10;
   localparam logic [1:0] T_RETN = 2'b11;

   localparam logic [RAS_W:0] OCC_FULL = (RAS_W+1)'(RAS_DEPTH);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic [1:0]       btype;
      logic [1:0]       count;
   } bht_entry_t;

   generate
      if (GHR_BITS < 1 || GHR_BITS > IDX || RAS_DEPTH < 2) begin : g_bad_cfg
         $error("bpu_param_predictor: GHR_BITS must be 1..log2(BHT_DEPTH) and RAS_DEPTH >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // BHT indexing
   // ------------------------------------------------------------------
   logic [IDX-1:0] rd_idx;
   logic [IDX-1:0] wr_idx;

`ifdef BPU_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   // history shifts in the outcome of every resolved conditional branch
   always_comb begin
      ghr_d = ghr_q;
      if (bus.exe_valid && bus.exe_type == T_IMME) begin
         ghr_d = GHR_BITS'({ghr_q, bus.exe_taken});
      end
   end

   // history register
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign rd_idx = bus.preif_pc[IDX+1:2] ^ IDX'(ghr_q);
   assign wr_idx = bus.exe_pc[IDX+1:2]   ^ IDX'(ghr_q);
`else
   assign rd_idx = bus.preif_pc[IDX+1:2];
   assign wr_idx = bus.exe_pc[IDX+1:2];
`endif

   // ------------------------------------------------------------------
   // BHT storage: contents in a RAM array, valid bits in flops so that
   // reset can clear them in one cycle.
   // ------------------------------------------------------------------
   bht_entry_t             entry_mem [BHT_DEPTH];
   logic [BHT_DEPTH-1:0]   valid_q;
   logic [BHT_DEPTH-1:0]   valid_d;
   bht_entry_t             wr_entry;
   bht_entry_t             rd_entry;
   logic                   lk_hit;
   logic [1:0]             new_count;

   // counter training: a fresh entry starts weak in the resolved direction,
   // a known entry saturates from the count carried with its prediction
   always_comb begin
      new_count = bus.exe_taken ? 2'b10 : 2'b01;
      if (bus.exe_hit) begin
         if (bus.exe_taken) begin
            new_count = (bus.exe_count == 2'b11) ? 2'b11 : bus.exe_count + 2'b01;
         end else begin
            new_count = (bus.exe_count == 2'b00) ? 2'b00 : bus.exe_count - 2'b01;
         end
      end
   end

   // assemble the entry written back by the resolved branch
   always_comb begin
      wr_entry.tag    = bus.exe_pc[31:IDX+2];
      wr_entry.target = bus.exe_target;
      wr_entry.btype  = bus.exe_type;
      wr_entry.count  = new_count;
   end

   // BHT array write; a same-cycle lookup of this index sees the old entry
   always_ff @(posedge clk) begin
      if (bus.exe_valid) begin
         entry_mem[wr_idx] <= wr_entry;
      end
   end

   // valid-bit next state
   always_comb begin
      valid_d = valid_q;
      if (bus.exe_valid) begin
         valid_d[wr_idx] = 1'b1;
      end
   end

   // valid-bit flops
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // combinational lookup on the PREIF PC
   always_comb begin
      rd_entry = entry_mem[rd_idx];
      lk_hit   = valid_q[rd_idx] && (rd_entry.tag == bus.preif_pc[31:IDX+2]);
   end

   // ------------------------------------------------------------------
   // Return-address stack
   // ------------------------------------------------------------------
   logic [31:0]      ras_mem [RAS_DEPTH];
   logic [RAS_W-1:0] top_q;
   logic [RAS_W-1:0] top_d;
   logic [RAS_W:0]   occ_q;
   logic [RAS_W:0]   occ_d;
   logic [RAS_W-1:0] ras_rd_ptr;
   logic             ras_push;
   logic             ras_pop;
   logic [31:0]      call_ret_addr;

   assign ras_push      = bus.exe_valid && (bus.exe_type == T_CALL);
   assign ras_pop       = bus.exe_valid && (bus.exe_type == T_RETN) && (occ_q != '0);
   assign call_ret_addr = bus.exe_pc + 32'd8;
   assign ras_rd_ptr    = top_q - RAS_W'(1);

   // RAS pointer/occupancy next state; a full stack keeps counting as full
   // while the write pointer wraps over the oldest entry
   always_comb begin
      top_d = top_q;
      occ_d = occ_q;
      if (ras_push) begin
         top_d = top_q + RAS_W'(1);
         if (occ_q != OCC_FULL) begin
            occ_d = occ_q + (RAS_W+1)'(1);
         end
      end else if (ras_pop) begin
         top_d = top_q - RAS_W'(1);
         occ_d = occ_q - (RAS_W+1)'(1);
      end
   end

   // RAS pointer/occupancy flops
   always_ff @(posedge clk) begin
      if (rst) begin
         top_q <= '0;
         occ_q <= '0;
      end else begin
         top_q <= top_d;
         occ_q <= occ_d;
      end
   end

   // RAS data write on a resolved call
   always_ff @(posedge clk) begin
      if (ras_push) begin
         ras_mem[top_q] <= call_ret_addr;
      end
   end

   // ------------------------------------------------------------------
   // Prediction register
   // ------------------------------------------------------------------
   logic        pv_q,      pv_d;
   logic        hit_q,     hit_d;
   logic [1:0]  type_q,    type_d;
   logic [1:0]  count_q,   count_d;
   logic [31:0] stgt_q,    stgt_d;
   logic [31:0] pc8_q,     pc8_d;
   logic [31:0] ras_tgt_q, ras_tgt_d;
   logic        ras_ok_q,  ras_ok_d;
   logic        taken_w;
   logic [31:0] target_w;

   // capture a lookup on IF advance; a flush kills it and leaves only the
   // sequential path; a call resolving in EXE is forwarded onto the RAS top
   always_comb begin
      pv_d      = pv_q;
      hit_d     = hit_q;
      type_d    = type_q;
      count_d   = count_q;
      stgt_d    = stgt_q;
      pc8_d     = pc8_q;
      ras_tgt_d = ras_tgt_q;
      ras_ok_d  = ras_ok_q;
      if (bus.if_flush) begin
         pv_d     = 1'b0;
         hit_d    = 1'b0;
         type_d   = T_NONE;
         count_d  = 2'b00;
         pc8_d    = bus.preif_pc + 32'd8;
         ras_ok_d = 1'b0;
      end else if (bus.if_wr) begin
         pv_d    = ~taken_w;
         hit_d   = lk_hit;
         type_d  = lk_hit ? rd_entry.btype : T_NONE;
         count_d = lk_hit ? rd_entry.count : 2'b00;
         stgt_d  = rd_entry.target;
         pc8_d   = bus.preif_pc + 32'd8;
         if (ras_push) begin
            ras_tgt_d = call_ret_addr;
            ras_ok_d  = 1'b1;
         end else begin
            ras_tgt_d = ras_mem[ras_rd_ptr];
            ras_ok_d  = (occ_q != '0);
         end
      end
   end

   // prediction register flops
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q      <= 1'b0;
         hit_q     <= 1'b0;
         type_q    <= T_NONE;
         count_q   <= 2'b00;
         stgt_q    <= '0;
         pc8_q     <= '0;
         ras_tgt_q <= '0;
         ras_ok_q  <= 1'b0;
      end else begin
         pv_q      <= pv_d;
         hit_q     <= hit_d;
         type_q    <= type_d;
         count_q   <= count_d;
         stgt_q    <= stgt_d;
         pc8_q     <= pc8_d;
         ras_tgt_q <= ras_tgt_d;
         ras_ok_q  <= ras_ok_d;
      end
   end

   // next-fetch selection from the registered prediction
   always_comb begin
      taken_w  = 1'b0;
      target_w = pc8_q;
      if (hit_q) begin
         case (type_q)
            T_CALL: begin
               taken_w  = 1'b1;
               target_w = stgt_q;
            end
            T_IMME: begin
               if (count_q[1]) begin
                  taken_w  = 1'b1;
                  target_w = stgt_q;
               end
            end
            T_RETN: begin
               taken_w = 1'b1;
               if (ras_ok_q) begin
                  target_w = ras_tgt_q;
               end
            end
            default: begin
               taken_w  = 1'b0;
               target_w = pc8_q;
            end
         endcase
      end
   end

   assign bus.target     = target_w;
   assign bus.pred_taken = taken_w;
   assign bus.pred_type  = type_q;
   assign bus.pred_hit   = hit_q;
   assign bus.pred_count = count_q;
   assign bus.pred_valid = pv_q;
   assign bus.ras_empty  = (occ_q == '0);

endmodule

// File: tb/tb_bpu_param_predictor.sv
// Self-checking bench for bpu_param_predictor: directed scenarios plus a
// randomized run compared against a behavioural model (array BHT, queue RAS).
module tb_bpu_param_predictor;
   localparam int BHT_DEPTH = 512;
   localparam int RAS_DEPTH = 8;
   localparam int GHR_BITS  = 8;
   localparam int IDX       = $clog2(BHT_DEPTH);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bpu_param_predictor_if bus();

   bpu_param_predictor #(
      .BHT_DEPTH(BHT_DEPTH),
      .RAS_DEPTH(RAS_DEPTH),
      .GHR_BITS (GHR_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // behavioural model state
   bit          m_valid [BHT_DEPTH];
   logic [31:0] m_pc    [BHT_DEPTH];
   logic [31:0] m_tgt   [BHT_DEPTH];
   logic [1:0]  m_type  [BHT_DEPTH];
   logic [1:0]  m_cnt   [BHT_DEPTH];
   logic [31:0] m_ras[$];
   int unsigned m_ghr;
   bit          e_valid, e_hit, e_taken, e_tknown;
   logic [1:0]  e_type, e_count;
   logic [31:0] e_target;

   function automatic int midx(logic [31:0] pc);
      int i;
      i = int'((pc >> 2) & (BHT_DEPTH - 1));
`ifdef BPU_GSHARE_EN
      i = i ^ int'(m_ghr);
`endif
      return i;
   endfunction

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      int          i;
      int          c;
      bit          h;
      bit          ne;
      logic [31:0] top;
      logic [31:0] pc8;
      if (rst) begin
         foreach (m_valid[k]) m_valid[k] = 1'b0;
         m_ras.delete();
         m_ghr    = 0;
         e_valid  = 0; e_hit = 0; e_taken = 0; e_tknown = 0;
         e_type   = 2'b00; e_count = 2'b00; e_target = 32'h0;
      end else begin
         if (bus.if_flush) begin
            e_valid = 0; e_hit = 0; e_taken = 0; e_tknown = 1;
            e_type = 2'b00; e_count = 2'b00; e_target = bus.preif_pc + 32'd8;
         end else if (bus.if_wr) begin
            i   = midx(bus.preif_pc);
            h   = m_valid[i] && ((m_pc[i] >> (IDX + 2)) == (bus.preif_pc >> (IDX + 2)));
            pc8 = bus.preif_pc + 32'd8;
            if (bus.exe_valid && bus.exe_type == 2'b10) begin
               ne = 1; top = bus.exe_pc + 32'd8;
            end else begin
               ne  = (m_ras.size() > 0);
               top = ne ? m_ras[$] : 32'h0;
            end
            e_valid  = !e_taken;
            e_hit    = h;
            e_tknown = 1;
            e_type   = h ? m_type[i] : 2'b00;
            e_count  = h ? m_cnt[i]  : 2'b00;
            e_taken  = 0;
            e_target = pc8;
            if (h) begin
               case (m_type[i])
                  2'b01: if (m_cnt[i] >= 2) begin e_taken = 1; e_target = m_tgt[i]; end
                  2'b10: begin e_taken = 1; e_target = m_tgt[i]; end
                  2'b11: begin e_taken = 1; if (ne) e_target = top; end
                  default: ;
               endcase
            end
         end
         if (bus.exe_valid) begin
            i = midx(bus.exe_pc);
            c = int'(bus.exe_count);
            if (!bus.exe_hit)      c = bus.exe_taken ? 2 : 1;
            else if (bus.exe_taken) c = (c < 3) ? c + 1 : 3;
            else                    c = (c > 0) ? c - 1 : 0;
            m_valid[i] = 1'b1;
            m_pc[i]    = bus.exe_pc;
            m_tgt[i]   = bus.exe_target;
            m_type[i]  = bus.exe_type;
            m_cnt[i]   = 2'(c);
            if (bus.exe_type == 2'b10) begin
               m_ras.push_back(bus.exe_pc + 32'd8);
               if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (bus.exe_type == 2'b11 && m_ras.size() > 0) begin
               void'(m_ras.pop_back());
            end
            if (bus.exe_type == 2'b01)
               m_ghr = ((m_ghr << 1) | int'(bus.exe_taken)) & ((1 << GHR_BITS) - 1);
         end
      end
   endtask

   task automatic idle_inputs();
      bus.if_wr = 0; bus.if_flush = 0; bus.preif_pc = 32'h0;
      bus.exe_valid = 0; bus.exe_pc = 32'h0; bus.exe_target = 32'h0;
      bus.exe_type = 2'b00; bus.exe_taken = 0; bus.exe_hit = 0; bus.exe_count = 2'b00;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      $display("cyc %0d rst=%b pc=%h wr=%b fl=%b exe=%b ty=%b epc=%h tk=%b -> tgt=%h taken=%b hit=%b cnt=%b valid=%b ras_empty=%b",
               cyc, rst, bus.preif_pc, bus.if_wr, bus.if_flush, bus.exe_valid, bus.exe_type,
               bus.exe_pc, bus.exe_taken, bus.target, bus.pred_taken, bus.pred_hit,
               bus.pred_count, bus.pred_valid, bus.ras_empty);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; tick(); tick();
      rst = 0;
   endtask

   task automatic exe_branch(logic [31:0] pc, logic [31:0] tgt, logic [1:0] ty,
                             logic tk, logic hit, logic [1:0] cnt);
      idle_inputs();
      bus.exe_valid = 1; bus.exe_pc = pc; bus.exe_target = tgt;
      bus.exe_type = ty; bus.exe_taken = tk; bus.exe_hit = hit; bus.exe_count = cnt;
      tick();
      idle_inputs();
   endtask

   task automatic lookup(logic [31:0] pc);
      idle_inputs();
      bus.preif_pc = pc; bus.if_wr = 1;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pred_valid: got %b expected 0", bus.pred_valid); end
      n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL reset_pred_hit: got %b expected 0", bus.pred_hit); end
      n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ras_empty: got %b expected 1", bus.ras_empty); end
      bus.preif_pc = 32'hBFC0_0000;
      tick();
      n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b expected 0", bus.pred_valid); end
      lookup(32'hBFC0_0000);
      n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL boot_hit: got %b expected 0", bus.pred_hit); end
      n_checks++; if (bus.target !== 32'hBFC0_0008) begin n_fail++; $display("FAIL boot_target: got %h expected bfc00008", bus.target); end
      n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL boot_taken: got %b expected 0", bus.pred_taken); end
      n_checks++; if (bus.pred_valid !== 1'b1) begin n_fail++; $display("FAIL boot_valid: got %b expected 1", bus.pred_valid); end
   endtask

   task automatic test_imme();
      exe_branch(32'h8000_1000, 32'h8000_2000, 2'b01, 1, 0, 2'b00);
      lookup(32'h8000_1000);
      n_checks++; if (bus.pred_hit !== 1'b1) begin n_fail++; $display("FAIL imme_hit: got %b expected 1", bus.pred_hit); end
      n_checks++; if (bus.pred_count !== 2'b10) begin n_fail++; $display("FAIL imme_count: got %b expected 10", bus.pred_count); end
      n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL imme_taken: got %b expected 1", bus.pred_taken); end
      n_checks++; if (bus.target !== 32'h8000_2000) begin n_fail++; $display("FAIL imme_target: got %h expected 80002000", bus.target); end
      n_checks++; if (bus.pred_type !== 2'b01) begin n_fail++; $display("FAIL imme_type: got %b expected 01", bus.pred_type); end
      exe_branch(32'h8000_1000, 32'h8000_2000, 2'b01, 0, 1, 2'b10);
      lookup(32'h8000_1000);
      n_checks++; if (bus.pred_count !== 2'b01) begin n_fail++; $display("FAIL imme_nt_count: got %b expected 01", bus.pred_count); end
      n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL imme_nt_taken: got %b expected 0", bus.pred_taken); end
      n_checks++; if (bus.target !== 32'h8000_1008) begin n_fail++; $display("FAIL imme_nt_target: got %h expected 80001008", bus.target); end
   endtask

   task automatic test_saturation();
      logic [31:0] pc;
      pc = 32'h8000_3200;
      exe_branch(pc, 32'h8000_4000, 2'b01, 1, 0, 2'b00);
      exe_branch(pc, 32'h8000_4000, 2'b01, 1, 1, 2'b10);
      for (int k = 0; k < 4; k++) begin
         exe_branch(pc, 32'h8000_4000, 2'b01, 1, 1, 2'b11);
         lookup(pc);
         n_checks++; if (bus.pred_count !== 2'b11) begin n_fail++; $display("FAIL sat_up_%0d count: got %b expected 11", k, bus.pred_count); end
      end
      exe_branch(pc, 32'h8000_4000, 2'b01, 0, 1, 2'b11);
      exe_branch(pc, 32'h8000_4000, 2'b01, 0, 1, 2'b10);
      exe_branch(pc, 32'h8000_4000, 2'b01, 0, 1, 2'b01);
      for (int k = 0; k < 4; k++) begin
         exe_branch(pc, 32'h8000_4000, 2'b01, 0, 1, 2'b00);
         lookup(pc);
         n_checks++; if (bus.pred_count !== 2'b00) begin n_fail++; $display("FAIL sat_dn_%0d count: got %b expected 00", k, bus.pred_count); end
         n_checks++; if (bus.target !== pc + 32'd8) begin n_fail++; $display("FAIL sat_dn_%0d target: got %h expected %h", k, bus.target, pc + 32'd8); end
      end
   endtask

   task automatic test_ras();
      logic [31:0] r_pc;
      logic [31:0] want;
      r_pc = 32'h8000_5040;
      do_reset();
      exe_branch(r_pc, 32'h0, 2'b11, 1, 0, 2'b00);
      for (int i = 0; i <= RAS_DEPTH; i++)
         exe_branch(32'h100 + 32'(i) * 32'h10, 32'h9000, 2'b10, 1, 0, 2'b00);
      n_checks++; if (bus.ras_empty !== 1'b0) begin n_fail++; $display("FAIL ras_full_empty: got %b expected 0", bus.ras_empty); end
      for (int k = 0; k < RAS_DEPTH; k++) begin
         lookup(r_pc);
         want = 32'h100 + 32'(RAS_DEPTH - k) * 32'h10 + 32'd8;
         n_checks++; if (bus.target !== want) begin n_fail++; $display("FAIL ras_pop_%0d target: got %h expected %h", k, bus.target, want); end
         n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ras_pop_%0d taken: got %b expected 1", k, bus.pred_taken); end
         exe_branch(r_pc, want, 2'b11, 1, 1, 2'b10);
      end
      n_checks++; if (bus.ras_empty !== 1'b1) begin n_fail++; $display("FAIL ras_drained_empty: got %b expected 1", bus.ras_empty); end
      lookup(r_pc);
      n_checks++; if (bus.target !== r_pc + 32'd8) begin n_fail++; $display("FAIL ras_underflow_target: got %h expected %h", bus.target, r_pc + 32'd8); end
      n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ras_underflow_taken: got %b expected 1", bus.pred_taken); end
   endtask

   task automatic test_bypass();
      idle_inputs();
      bus.preif_pc = 32'h8000_5040; bus.if_wr = 1;
      bus.exe_valid = 1; bus.exe_pc = 32'h400; bus.exe_target = 32'h9400;
      bus.exe_type = 2'b10; bus.exe_taken = 1;
      tick();
      idle_inputs();
      n_checks++; if (bus.target !== 32'h408) begin n_fail++; $display("FAIL bypass_target: got %h expected 00000408", bus.target); end
      n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL bypass_taken: got %b expected 1", bus.pred_taken); end
   endtask

   task automatic test_flush();
      logic [31:0] held;
      idle_inputs();
      bus.preif_pc = 32'h8000_1000; bus.if_wr = 1; bus.if_flush = 1;
      tick();
      idle_inputs();
      n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.pred_valid); end
      n_checks++; if (bus.pred_hit !== 1'b0) begin n_fail++; $display("FAIL flush_hit: got %b expected 0", bus.pred_hit); end
      n_checks++; if (bus.target !== 32'h8000_1008) begin n_fail++; $display("FAIL flush_target: got %h expected 80001008", bus.target); end
      lookup(32'h100);
      n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL call_taken: got %b expected 1", bus.pred_taken); end
      n_checks++; if (bus.target !== 32'h9000) begin n_fail++; $display("FAIL call_target: got %h expected 00009000", bus.target); end
      n_checks++; if (bus.pred_valid !== 1'b1) begin n_fail++; $display("FAIL call_valid: got %b expected 1", bus.pred_valid); end
      lookup(32'h8000_1000);
      n_checks++; if (bus.pred_valid !== 1'b0) begin n_fail++; $display("FAIL after_taken_valid: got %b expected 0", bus.pred_valid); end
      held = bus.target;
      bus.preif_pc = 32'h100;
      tick();
      n_checks++; if (bus.target !== e_target || held !== e_target) begin n_fail++; $display("FAIL hold_target: got %h expected %h", bus.target, e_target); end
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] pc;
      pc = 32'h8000_0000 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) pc = pc + 32'h800;
      return pc;
   endfunction

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 300; n++) begin
         rst            = ($urandom_range(0, 99) == 0);
         bus.if_wr      = ($urandom_range(0, 9) < 7);
         bus.if_flush   = ($urandom_range(0, 9) == 0);
         bus.preif_pc   = rand_pc();
         bus.exe_valid  = ($urandom_range(0, 1) == 1);
         bus.exe_pc     = rand_pc();
         bus.exe_target = $urandom & 32'hFFFF_FFFC;
         bus.exe_type   = 2'($urandom_range(0, 3));
         bus.exe_taken  = 1'($urandom_range(0, 1));
         bus.exe_hit    = 1'($urandom_range(0, 1));
         bus.exe_count  = 2'($urandom_range(0, 3));
         tick();
         n_checks++; if (bus.pred_valid !== e_valid) begin n_fail++; $display("FAIL rnd_%0d valid: got %b expected %b", n, bus.pred_valid, e_valid); end
         n_checks++; if (bus.pred_hit !== e_hit) begin n_fail++; $display("FAIL rnd_%0d hit: got %b expected %b", n, bus.pred_hit, e_hit); end
         n_checks++; if (bus.pred_taken !== e_taken) begin n_fail++; $display("FAIL rnd_%0d taken: got %b expected %b", n, bus.pred_taken, e_taken); end
         n_checks++; if (bus.pred_type !== e_type) begin n_fail++; $display("FAIL rnd_%0d type: got %b expected %b", n, bus.pred_type, e_type); end
         n_checks++; if (bus.ras_empty !== (m_ras.size() == 0)) begin n_fail++; $display("FAIL rnd_%0d ras_empty: got %b expected %b", n, bus.ras_empty, m_ras.size() == 0); end
         if (e_tknown) begin
            n_checks++; if (bus.target !== e_target) begin n_fail++; $display("FAIL rnd_%0d target: got %h expected %h", n, bus.target, e_target); end
         end
         if (e_hit) begin
            n_checks++; if (bus.pred_count !== e_count) begin n_fail++; $display("FAIL rnd_%0d count: got %b expected %b", n, bus.pred_count, e_count); end
         end
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_imme();
      test_saturation();
      test_ras();
      test_bypass();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
